// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared state encoding and constants for the capsense touch filter
package touch_pkg;

  typedef enum logic [1:0] {
    ST_CAL     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2
  } touch_state_t;

  localparam int          CAL_SAMPLES = 8;
  localparam logic [11:0] ACC_MAX     = 12'hFF0;

  function automatic logic [7:0] sat_delta(input logic [7:0] f, input logic [7:0] b);
    return (f > b) ? (f - b) : 8'd0;
  endfunction

endpackage

// File: rtl/iir_step.sv
// rtl/iir_step.sv - one first-order IIR update of an 8.4 accumulator toward an 8-bit target
module iir_step
  import touch_pkg::*;
(
  input  logic [11:0] acc,
  input  logic [7:0]  sample,
  input  logic [3:0]  shift,
  output logic [11:0] acc_next
);

  logic signed [12:0] diff;
  logic signed [12:0] step;
  logic signed [13:0] sum;

  always_comb begin
    diff = $signed({1'b0, sample, 4'b0000}) - $signed({1'b0, acc});
    step = diff >>> shift;
    sum  = $signed({step[12], step}) + $signed({2'b00, acc});
    if (sum < 14'sd0) begin
      acc_next = 12'd0;
    end else if (sum > $signed({2'b00, ACC_MAX})) begin
      acc_next = ACC_MAX;
    end else begin
      acc_next = sum[11:0];
    end
  end

endmodule

// File: rtl/touch_filter.sv
// rtl/touch_filter.sv - capsense sample smoothing, baseline tracking and debounced touch detection
module touch_filter
  import touch_pkg::*;
#(
  parameter int          AVG_SHIFT     = 2,
  parameter int          BASE_SHIFT    = 4,
  parameter logic [7:0]  THRESH_ON     = 8'd3,
  parameter logic [7:0]  THRESH_OFF    = 8'd1,
  parameter int          DEBOUNCE      = 3,
  parameter logic [15:0] PRESS_TIMEOUT = 16'd4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       recal,
  output logic       touched,
  output logic       press,
  output logic       release_pulse,
  output logic [7:0] filtered,
  output logic [7:0] baseline,
  output logic [7:0] delta,
  output logic       calibrating
);

  touch_state_t state, state_n;
  logic [1:0]   sync;
  logic         ready;
  logic [2:0]   cal_cnt, cal_cnt_n;
  logic [10:0]  cal_sum, cal_sum_n, cal_total;
  logic [11:0]  filt_acc, filt_n, filt_step;
  logic [11:0]  base_acc, base_n, base_step;
  logic [7:0]   deb_cnt, deb_n;
  logic [15:0]  hold_cnt, hold_n;
  logic         touched_n, press_n, release_n;
  logic [7:0]   delta_n, d_run;

  // inputs are ignored until the reset release has crossed two flops
  assign ready = sync[1];

  iir_step u_filt (.acc(filt_acc), .sample(sample),          .shift(4'(AVG_SHIFT)),  .acc_next(filt_step));
  iir_step u_base (.acc(base_acc), .sample(filt_acc[11:4]),  .shift(4'(BASE_SHIFT)), .acc_next(base_step));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync          <= 2'b00;
      state         <= ST_CAL;
      cal_cnt       <= '0;
      cal_sum       <= '0;
      filt_acc      <= '0;
      base_acc      <= '0;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      touched       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      delta         <= '0;
    end else begin
      sync          <= {sync[0], 1'b1};
      state         <= state_n;
      cal_cnt       <= cal_cnt_n;
      cal_sum       <= cal_sum_n;
      filt_acc      <= filt_n;
      base_acc      <= base_n;
      deb_cnt       <= deb_n;
      hold_cnt      <= hold_n;
      touched       <= touched_n;
      press         <= press_n;
      release_pulse <= release_n;
      delta         <= delta_n;
    end
  end

  always_comb begin
    state_n   = state;
    cal_cnt_n = cal_cnt;
    cal_sum_n = cal_sum;
    filt_n    = filt_acc;
    base_n    = base_acc;
    deb_n     = deb_cnt;
    hold_n    = hold_cnt;
    touched_n = touched;
    press_n   = 1'b0;
    release_n = 1'b0;
    delta_n   = delta;
    d_run     = '0;
    cal_total = cal_sum + {3'b000, sample};

    if (ready && recal) begin
      state_n   = ST_CAL;
      cal_cnt_n = '0;
      cal_sum_n = '0;
      deb_n     = '0;
      hold_n    = '0;
      touched_n = 1'b0;
      release_n = touched;
    end else if (ready && sample_valid) begin
      unique case (state)
        ST_CAL: begin
          if (cal_cnt == 3'(CAL_SAMPLES - 1)) begin
            filt_n    = {cal_total[10:3], 4'b0000};
            base_n    = {cal_total[10:3], 4'b0000};
            delta_n   = '0;
            state_n   = ST_IDLE;
            cal_cnt_n = '0;
            cal_sum_n = '0;
            deb_n     = '0;
            hold_n    = '0;
          end else begin
            cal_cnt_n = cal_cnt + 3'd1;
            cal_sum_n = cal_total;
          end
        end
        ST_IDLE: begin
          filt_n  = filt_step;
          base_n  = base_step;
          d_run   = sat_delta(filt_step[11:4], base_step[11:4]);
          delta_n = d_run;
          deb_n   = (d_run >= THRESH_ON) ? deb_cnt + 8'd1 : 8'd0;
          if (deb_n >= 8'(DEBOUNCE)) begin
            state_n   = ST_PRESSED;
            touched_n = 1'b1;
            press_n   = 1'b1;
            deb_n     = '0;
            hold_n    = '0;
          end
        end
        ST_PRESSED: begin
          // baseline frozen so a long press is not absorbed into it
          filt_n  = filt_step;
          d_run   = sat_delta(filt_step[11:4], base_acc[11:4]);
          delta_n = d_run;
          hold_n  = hold_cnt + 16'd1;
          deb_n   = (d_run <= THRESH_OFF) ? deb_cnt + 8'd1 : 8'd0;
          if (PRESS_TIMEOUT != 16'd0 && hold_n == PRESS_TIMEOUT) begin
            state_n   = ST_CAL;
            touched_n = 1'b0;
            release_n = 1'b1;
            deb_n     = '0;
            hold_n    = '0;
            cal_cnt_n = '0;
            cal_sum_n = '0;
          end else if (deb_n >= 8'(DEBOUNCE)) begin
            state_n   = ST_IDLE;
            touched_n = 1'b0;
            release_n = 1'b1;
            deb_n     = '0;
            hold_n    = '0;
          end
        end
        default: state_n = ST_CAL;
      endcase
    end
  end

  assign filtered    = filt_acc[11:4];
  assign baseline    = base_acc[11:4];
  assign calibrating = (state == ST_CAL);

endmodule

// File: doc/touch_filter.md
TOUCH_FILTER -- requirements
Module: touch_filter

Interface
REQ-001 SHALL have parameter AVG_SHIFT, default 2, meaning sample IIR weight 2^-AVG_SHIFT.
REQ-002 SHALL have parameter BASE_SHIFT, default 4, meaning baseline IIR weight 2^-BASE_SHIFT.
REQ-003 SHALL have parameter THRESH_ON, default 8'd3, meaning delta needed to count toward a press.
REQ-004 SHALL have parameter THRESH_OFF, default 8'd1, meaning delta at or below which a sample counts toward a release.
REQ-005 SHALL have parameter DEBOUNCE, default 3, meaning consecutive qualifying samples required for a transition.
REQ-006 SHALL have parameter PRESS_TIMEOUT, default 16'd4096, meaning maximum samples held pressed before forced recalibration; 0 disables.
REQ-007 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port sample  in  8  raw charge-time count from capsense.
REQ-009 SHALL have port sample_valid  in  1  one-cycle strobe marking a new sample.
REQ-010 SHALL have port recal  in  1  one-cycle request to restart calibration.
REQ-011 SHALL have ports touched out 1 debounced state; press out 1 one-cycle rise pulse; release out 1 one-cycle fall pulse.
REQ-012 SHALL have ports filtered out 8, baseline out 8, delta out 8, and calibrating out 1 (high while in CAL).

Function
REQ-013 SHALL update state only on cycles with sample_valid=1; all outputs SHALL be registered and change one cycle after the strobe.
REQ-014 SHALL implement states CAL, IDLE, PRESSED.
REQ-015 In CAL it SHALL sum exactly 8 valid samples into an 11-bit accumulator; on the 8th it SHALL load filt_acc and base_acc with {sum[10:3],4'b0}, then go to IDLE.
REQ-016 filt_acc and base_acc SHALL be 12-bit unsigned 8.4 fixed point; filtered=filt_acc[11:4] and baseline=base_acc[11:4].
REQ-017 In IDLE/PRESSED, filt_acc SHALL be updated to filt_acc + (({sample,4'b0} - filt_acc) >>> AVG_SHIFT), computed in 13-bit signed arithmetic.
REQ-018 base_acc SHALL track filt_acc the same way with BASE_SHIFT in IDLE only, and SHALL be frozen in PRESSED.
REQ-019 delta SHALL equal filtered - baseline when filtered > baseline, else 0 (saturating, never wraps).
REQ-020 In IDLE, a debounce counter SHALL increment on each sample with delta >= THRESH_ON and clear otherwise; at DEBOUNCE it SHALL enter PRESSED, set touched, pulse press, and clear.
REQ-021 In PRESSED, the counter SHALL increment on delta <= THRESH_OFF, clear otherwise; at DEBOUNCE it SHALL enter IDLE, clear touched, and pulse release.
REQ-022 In PRESSED, a 16-bit hold counter SHALL increment per sample; when it reaches PRESS_TIMEOUT (non-zero) the block SHALL pulse release, clear touched, and enter CAL.
REQ-023 recal SHALL take priority over sample_valid in the same cycle: enter CAL, clear counters, clear touched, and pulse release only if touched was 1.
REQ-024 press and release SHALL never be high in the same cycle; touched SHALL be 0 throughout CAL.
REQ-025 Computed deltas outside 0..255 SHALL saturate; accumulators SHALL clamp to 0..12'hFF0.

Reset
REQ-026 On reset_n=0 the block SHALL enter CAL with touched=0, press=0, release=0, filtered=0, baseline=0, delta=0, calibrating=1, and all counters and accumulators at 0.
REQ-027 Deassertion SHALL be synchronised so that no sample is consumed in the first cycle after release.

Structure
REQ-028 State encodings and the fixed CAL sample count (8) SHALL live in a shared package touch_pkg.
REQ-029 The IIR update SHALL be a sub-module iir_step (inputs acc, sample, shift; output next acc), instantiated twice.

Verification
REQ-030 Eight samples of 20, then 20 constant -> calibrating falls after the 8th strobe; baseline=20, filtered=20, delta=0, touched=0.
REQ-031 After calibration, sample held at 40 -> filtered rises 20->25->28..., touched rises and press pulses once exactly on the 3rd strobe with delta>=3; baseline is then frozen.
REQ-032 While pressed, sample returns to 20 -> release pulses once on the 3rd consecutive strobe with delta<=1; baseline stays 20 throughout.
REQ-033 Delta alternating 3,0,3,0 -> no press (debounce counter clears each time).
REQ-034 PRESS_TIMEOUT=16 with sample held at 60 -> release pulses on the 16th pressed strobe, calibrating=1, then new baseline recalibrates to 60.
REQ-035 recal and sample_valid in the same cycle while pressed, and reset_n asserted mid-CAL -> CAL entered, one release pulse for the recal, all outputs at reset values with no stray press.
